// File: rtl/idex_operand_stage.sv
// ============================================================================
// Module      : idex_operand_stage
// Description : ID/EX pipeline register with operand forwarding (EX/MEM/WB),
//               load-use bubble insertion, stall/flush handling and a
//               saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  output logic             o_id_ready,
  input  logic [XLEN-1:0]  i_id_pc,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [XLEN-1:0]  i_id_rd1,
  input  logic [XLEN-1:0]  i_id_rd2,
  input  logic [XLEN-1:0]  i_id_imm,
  input  logic             i_id_asrc,
  input  logic             i_id_bsrc,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [2:0]       i_id_aluop,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic             i_id_memwrite,
  input  logic [XLEN-1:0]  i_ex_alu_c,
  input  logic             i_mem_regwrite,
  input  logic [4:0]       i_mem_rd,
  input  logic [XLEN-1:0]  i_mem_data,
  input  logic             i_wb_regwrite,
  input  logic [4:0]       i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_ex_valid,
  output logic [XLEN-1:0]  o_ex_a,
  output logic [XLEN-1:0]  o_ex_b,
  output logic [2:0]       o_ex_aluop,
  output logic [XLEN-1:0]  o_ex_store_data,
  output logic [XLEN-1:0]  o_ex_pc,
  output logic [4:0]       o_ex_rd,
  output logic             o_ex_regwrite,
  output logic             o_ex_memread,
  output logic             o_ex_memwrite,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam logic [2:0]       c_ALU_NOP = 3'b000;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_ex_valid;
  logic [XLEN-1:0]  r_ex_a;
  logic [XLEN-1:0]  r_ex_b;
  logic [2:0]       r_ex_aluop;
  logic [XLEN-1:0]  r_ex_store_data;
  logic [XLEN-1:0]  r_ex_pc;
  logic [4:0]       r_ex_rd;
  logic             r_ex_regwrite;
  logic             r_ex_memread;
  logic             r_ex_memwrite;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic [XLEN-1:0]  w_r1;
  logic [XLEN-1:0]  w_r2;
  logic             w_hz;

  // Youngest producer wins; a load in EX has no result yet, so it is skipped
  // here and covered by the load-use bubble instead.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0)
      return '0;
    else if (r_ex_valid && r_ex_regwrite && (r_ex_rd == rs) && !r_ex_memread)
      return i_ex_alu_c;
    else if (i_mem_regwrite && (i_mem_rd == rs))
      return i_mem_data;
    else if (i_wb_regwrite && (i_wb_rd == rs))
      return i_wb_data;
    else
      return rf;
  endfunction

  // Forwarded source operands and load-use hazard detection.
  always_comb begin
    w_r1 = fwd(i_id_rs1, i_id_rd1);
    w_r2 = fwd(i_id_rs2, i_id_rd2);
    w_hz = i_id_valid && r_ex_valid && r_ex_memread && (r_ex_rd != 5'd0) &&
           ((i_id_use_rs1 && (r_ex_rd == i_id_rs1)) ||
            (i_id_use_rs2 && (r_ex_rd == i_id_rs2)));
  end

  assign o_id_ready = !rst && !i_stall && !w_hz;

  // Pipeline register update: reset > flush > stall > hazard > capture > idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid      <= 1'b0;
      r_ex_a          <= '0;
      r_ex_b          <= '0;
      r_ex_aluop      <= c_ALU_NOP;
      r_ex_store_data <= '0;
      r_ex_pc         <= '0;
      r_ex_rd         <= '0;
      r_ex_regwrite   <= 1'b0;
      r_ex_memread    <= 1'b0;
      r_ex_memwrite   <= 1'b0;
      r_bubble_cnt    <= '0;
    end else if (i_stall && !i_flush) begin
      // Held entry keeps its captured operands; nothing is re-forwarded.
    end else if (i_flush || w_hz || !i_id_valid) begin
      r_ex_valid      <= 1'b0;
      r_ex_a          <= '0;
      r_ex_b          <= '0;
      r_ex_aluop      <= c_ALU_NOP;
      r_ex_store_data <= '0;
      r_ex_pc         <= '0;
      r_ex_rd         <= '0;
      r_ex_regwrite   <= 1'b0;
      r_ex_memread    <= 1'b0;
      r_ex_memwrite   <= 1'b0;
      if (!i_flush && w_hz && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
    end else begin
      r_ex_valid      <= 1'b1;
      r_ex_a          <= i_id_asrc ? i_id_pc  : w_r1;
      r_ex_b          <= i_id_bsrc ? i_id_imm : w_r2;
      r_ex_aluop      <= i_id_aluop;
      r_ex_store_data <= w_r2;
      r_ex_pc         <= i_id_pc;
      r_ex_rd         <= i_id_rd;
      r_ex_regwrite   <= i_id_regwrite;
      r_ex_memread    <= i_id_memread;
      r_ex_memwrite   <= i_id_memwrite;
    end
  end

  assign o_ex_valid      = r_ex_valid;
  assign o_ex_a          = r_ex_a;
  assign o_ex_b          = r_ex_b;
  assign o_ex_aluop      = r_ex_aluop;
  assign o_ex_store_data = r_ex_store_data;
  assign o_ex_pc         = r_ex_pc;
  assign o_ex_rd         = r_ex_rd;
  assign o_ex_regwrite   = r_ex_regwrite;
  assign o_ex_memread    = r_ex_memread;
  assign o_ex_memwrite   = r_ex_memwrite;
  assign o_bubble_cnt    = r_bubble_cnt;

endmodule

`default_nettype wire
